// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON byte-stream controller: data_rdy codes,
// controller FSM states and default block/key sizes.
package simon_pkg;

    localparam int SIMON_BLOCK_BITS = 32;
    localparam int SIMON_KEY_BITS   = 64;

    // Encoding of simon_module data_rdy
    typedef enum logic [1:0] {
        RDY_IDLE = 2'd0,
        RDY_PT   = 2'd1,
        RDY_KEY  = 2'd2,
        RDY_RUN  = 2'd3
    } rdy_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD_PT,
        LOAD_KEY,
        RUN,
        CAPTURE,
        EMIT
    } state_e;

endpackage

// File: rtl/simon_byte_serdes.sv
// BLOCK_BITS shift register with parallel byte write, indexed byte read and a
// 1-bit serial path. Shifting is towards bit 0: the serial output presents the
// LSB first, and serial input enters at the MSB so that after BLOCK_BITS
// shifts the first bit received sits in bit 0.
module simon_byte_serdes
    import simon_pkg::*;
#(
    parameter int BLOCK_BITS = SIMON_BLOCK_BITS,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load_en,
    input  logic [IDX_W-1:0] i_load_idx,
    input  logic [7:0]       i_load_byte,
    input  logic             i_shift_en,
    input  logic             i_ser_in,
    output logic             o_ser_out,
    output logic             o_ser_next,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_byte
);

    localparam int NBYTES = BLOCK_BITS / 8;

    logic [BLOCK_BITS-1:0] r_data;

    // Clear has priority over a byte write, which has priority over a shift
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (i_load_idx == IDX_W'(k)) begin
                    r_data[8*k +: 8] <= i_load_byte;
                end
            end
        end else if (i_shift_en) begin
            r_data <= {i_ser_in, r_data[BLOCK_BITS-1:1]};
        end
    end

    // Current serial bit and the one after it (lets the caller register a
    // look-ahead copy of the stream)
    assign o_ser_out  = r_data[0];
    assign o_ser_next = r_data[1];

    // Indexed byte read
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        o_rd_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                o_rd_byte = r_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/simon_stream_ctrl.sv
// Host byte-stream front end for simon_module: gathers a plaintext block from
// host bytes, serialises it (then a zero key phase) into simon_module, waits
// for the bit-serial ciphertext and returns it to the host byte by byte.
module simon_stream_ctrl
    import simon_pkg::*;
#(
    parameter int BLOCK_BITS  = SIMON_BLOCK_BITS,
    parameter int KEY_BITS    = SIMON_KEY_BITS,
    parameter int RUN_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_valid,
    output logic       byte_in_ready,
    output logic [7:0] byte_out,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       busy,
    output logic       err,
    output logic       sim_data,
    output logic [1:0] sim_data_rdy,
    input  logic       sim_cipher,
    input  logic       sim_valid
);

    localparam int NBYTES     = BLOCK_BITS / 8;
    localparam int BYTE_CNT_W = $clog2(NBYTES) + 1;
    localparam int BIT_CNT_W  = $clog2(KEY_BITS) + 1;
    localparam int TO_CNT_W   = $clog2(RUN_TIMEOUT) + 1;

    localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(NBYTES - 1);
    localparam logic [BIT_CNT_W-1:0]  PT_LAST   = BIT_CNT_W'(BLOCK_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  KEY_LAST  = BIT_CNT_W'(KEY_BITS - 1);
    // Bit 0 of the ciphertext is taken on the RUN->CAPTURE edge, so CAPTURE
    // itself sees BLOCK_BITS-1 more bits.
    localparam logic [BIT_CNT_W-1:0]  CAP_LAST  = BIT_CNT_W'(BLOCK_BITS - 2);
    localparam logic [TO_CNT_W-1:0]   TO_LAST   = TO_CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [TO_CNT_W-1:0]   TO_MAX    = '1;

    state_e                r_state;
    rdy_e                  r_sim_data_rdy;
    logic                  r_sim_data;
    logic                  r_byte_in_ready;
    logic                  r_byte_out_valid;
    logic                  r_err;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [TO_CNT_W-1:0]   r_to_cnt;

    logic       w_in_xfer;
    logic       w_out_xfer;
    logic       w_shift_en;
    logic       w_ser_in;
    logic       w_clear;
    logic       w_ser_out;
    logic       w_ser_next;
    logic [7:0] w_rd_byte;

    assign w_in_xfer  = byte_in_valid & r_byte_in_ready;
    assign w_out_xfer = r_byte_out_valid & byte_out_ready;

    // Plaintext shifts out (zero-filling) in LOAD_PT; ciphertext shifts in
    // whenever simon_module flags a valid bit in RUN or CAPTURE.
    assign w_shift_en = (r_state == LOAD_PT)
                      | (((r_state == RUN) | (r_state == CAPTURE)) & sim_valid);
    assign w_ser_in   = (r_state == LOAD_PT) ? 1'b0 : sim_cipher;
    // Discard a short burst, and leave the register empty after the last byte
    assign w_clear    = ((r_state == CAPTURE) & ~sim_valid)
                      | ((r_state == EMIT) & w_out_xfer & (r_byte_cnt == BYTE_LAST));

    simon_byte_serdes #(
        .BLOCK_BITS (BLOCK_BITS),
        .IDX_W      (BYTE_CNT_W)
    ) u_serdes (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load_en   (w_in_xfer),
        .i_load_idx  (r_byte_cnt),
        .i_load_byte (byte_in),
        .i_shift_en  (w_shift_en),
        .i_ser_in    (w_ser_in),
        .o_ser_out   (w_ser_out),
        .o_ser_next  (w_ser_next),
        .i_rd_idx    (r_byte_cnt),
        .o_rd_byte   (w_rd_byte)
    );

    // Controller FSM with registered handshake and simon_module outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_sim_data_rdy   <= RDY_IDLE;
            r_sim_data       <= 1'b0;
            r_byte_in_ready  <= 1'b0;
            r_byte_out_valid <= 1'b0;
            r_err            <= 1'b0;
            r_byte_cnt       <= '0;
            r_bit_cnt        <= '0;
            r_to_cnt         <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    r_byte_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        if (r_byte_cnt == BYTE_LAST) begin
                            r_state         <= LOAD_PT;
                            r_byte_in_ready <= 1'b0;
                            r_byte_cnt      <= '0;
                            r_bit_cnt       <= '0;
                            r_sim_data_rdy  <= RDY_PT;
                            // Bit 0 lives in byte 0, which is only in the
                            // register already if this is not byte 0.
                            r_sim_data      <= (r_byte_cnt == '0) ? byte_in[0] : w_ser_out;
                        end else begin
                            r_state    <= COLLECT;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end

                LOAD_PT: begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    r_sim_data <= w_ser_next;
                    if (r_bit_cnt == PT_LAST) begin
                        r_state        <= LOAD_KEY;
                        r_bit_cnt      <= '0;
                        r_sim_data_rdy <= RDY_KEY;
                        r_sim_data     <= 1'b0;
                    end
                end

                LOAD_KEY: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == KEY_LAST) begin
                        r_state        <= RUN;
                        r_bit_cnt      <= '0;
                        r_to_cnt       <= '0;
                        r_sim_data_rdy <= RDY_RUN;
                    end
                end

                RUN: begin
                    if (r_to_cnt != TO_MAX) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (sim_valid) begin
                        r_state   <= CAPTURE;
                        r_bit_cnt <= '0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state         <= IDLE;
                        r_err           <= 1'b1;
                        r_sim_data_rdy  <= RDY_IDLE;
                        r_byte_in_ready <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (!sim_valid) begin
                        r_state         <= IDLE;
                        r_err           <= 1'b1;
                        r_sim_data_rdy  <= RDY_IDLE;
                        r_bit_cnt       <= '0;
                        r_byte_in_ready <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CAP_LAST) begin
                            r_state          <= EMIT;
                            r_bit_cnt        <= '0;
                            r_byte_cnt       <= '0;
                            r_sim_data_rdy   <= RDY_IDLE;
                            r_byte_out_valid <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (w_out_xfer) begin
                        if (r_byte_cnt == BYTE_LAST) begin
                            r_state          <= IDLE;
                            r_byte_out_valid <= 1'b0;
                            r_byte_cnt       <= '0;
                            r_byte_in_ready  <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The byte index only advances on a transfer, so byte_out is stable while
    // the host stalls; it reads as zero whenever nothing is offered.
    assign byte_out       = r_byte_out_valid ? w_rd_byte : 8'h00;
    assign byte_out_valid = r_byte_out_valid;
    assign byte_in_ready  = r_byte_in_ready;
    assign busy           = (r_state != IDLE);
    assign err            = r_err;
    assign sim_data       = r_sim_data;
    assign sim_data_rdy   = r_sim_data_rdy;

endmodule
